// File: rtl/switch_filter_n.sv
// switch_filter_n: NUM_CH-channel switch debouncer with saturating integrators,
// hysteresis, rise/fall edge pulses and a maskable sticky change interrupt.
// Optional build macro SWITCH_FILTER_SYNC_EN inserts a 2-flop synchroniser per
// channel ahead of the integrators (adds exactly 2 cycles of latency).
module switch_filter_n #(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 6,
  parameter bit OUT_INIT = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] switch_in,
  output logic [NUM_CH-1:0] switch_out,
  output logic [NUM_CH-1:0] rise,
  output logic [NUM_CH-1:0] fall,
  input  logic [NUM_CH-1:0] irq_mask,
  input  logic [NUM_CH-1:0] irq_ack,
  output logic [NUM_CH-1:0] pending,
  output logic              irq
);

  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CMID = {1'b1, {(CNT_W-1){1'b0}}};

  logic [CNT_W-1:0]  cnt      [NUM_CH];
  logic [CNT_W-1:0]  cnt_next [NUM_CH];
  logic [NUM_CH-1:0] sample;
  logic              run;
  logic [NUM_CH-1:0] out_next;
  logic [NUM_CH-1:0] rise_next;
  logic [NUM_CH-1:0] fall_next;
  logic [NUM_CH-1:0] pend_next;

`ifdef SWITCH_FILTER_SYNC_EN
  logic [NUM_CH-1:0] sync1;
  logic [NUM_CH-1:0] sync2;
  logic [1:0]        warm;

  // Two-flop synchroniser; warm holds the integrators until real samples arrive
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      warm  <= '0;
    end else begin
      sync1 <= switch_in;
      sync2 <= sync1;
      warm  <= {warm[0], 1'b1};
    end
  end

  assign sample = sync2;
  assign run    = warm[1];
`else
  assign sample = switch_in;
  assign run    = 1'b1;
`endif

  // Per-channel integrator step, hysteresis decision and interrupt next-state
  always_comb begin
    out_next = switch_out;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_next[i] = cnt[i];
      if (run) begin
        if (sample[i] && (cnt[i] != CMAX)) begin
          cnt_next[i] = cnt[i] + CNT_W'(1);
        end else if (!sample[i] && (cnt[i] != '0)) begin
          cnt_next[i] = cnt[i] - CNT_W'(1);
        end
      end
      if (cnt[i] == CMAX) begin
        out_next[i] = 1'b1;
      end else if (cnt[i] == '0) begin
        out_next[i] = 1'b0;
      end
    end
    rise_next = out_next & ~switch_out;
    fall_next = ~out_next & switch_out;
    pend_next = (pending & ~irq_ack) | ((rise_next | fall_next) & irq_mask);
  end

  // State and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i] <= CMID;
      end
      switch_out <= {NUM_CH{OUT_INIT}};
      rise       <= '0;
      fall       <= '0;
      pending    <= '0;
      irq        <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i] <= cnt_next[i];
      end
      switch_out <= out_next;
      rise       <= rise_next;
      fall       <= fall_next;
      pending    <= pend_next;
      irq        <= |pend_next;
    end
  end

endmodule

// File: tb/tb_switch_filter_n.sv
// tb_switch_filter_n: scoreboard bench for switch_filter_n. Stimulus pushes
// cycle-tagged expectations; a monitor compares them on the falling edge.
module tb_switch_filter_n;

`ifdef SWITCH_FILTER_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] a_in, a_out, a_rise, a_fall, a_mask, a_ack, a_pend;
  logic       a_irq;
  logic       b_reset;
  logic [7:0] b_in, b_out, b_rise, b_fall, b_mask, b_ack, b_pend;
  logic       b_irq;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    int         dut;
    string      name;
    logic [7:0] so;
    logic [7:0] ri;
    logic [7:0] fa;
    logic [7:0] pe;
    logic       irq;
  } exp_t;

  exp_t q[$];

  switch_filter_n dut_a (
    .clock(clock), .reset(reset), .switch_in(a_in), .switch_out(a_out),
    .rise(a_rise), .fall(a_fall), .irq_mask(a_mask), .irq_ack(a_ack),
    .pending(a_pend), .irq(a_irq)
  );

  switch_filter_n #(.NUM_CH(8), .CNT_W(3), .OUT_INIT(1'b1)) dut_b (
    .clock(clock), .reset(b_reset), .switch_in(b_in), .switch_out(b_out),
    .rise(b_rise), .fall(b_fall), .irq_mask(b_mask), .irq_ack(b_ack),
    .pending(b_pend), .irq(b_irq)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic push(input int c, input int d, input string n, input logic [7:0] so,
                      input logic [7:0] ri, input logic [7:0] fa, input logic [7:0] pe,
                      input logic irq);
    exp_t e;
    e.cyc = c; e.dut = d; e.name = n;
    e.so = so; e.ri = ri; e.fa = fa; e.pe = pe; e.irq = irq;
    q.push_back(e);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Monitor: compare every expectation whose cycle has come
  always @(negedge clock) begin
    logic [32:0] act, req;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc <= cyc) begin
        if (q[i].dut == 0) act = {8'(a_out), 8'(a_rise), 8'(a_fall), 8'(a_pend), a_irq};
        else               act = {b_out, b_rise, b_fall, b_pend, b_irq};
        req = {q[i].so, q[i].ri, q[i].fa, q[i].pe, q[i].irq};
        checks++;
        if (q[i].cyc < cyc) begin
          errors++;
          $display("FAIL %s: expectation for cycle %0d missed at cycle %0d", q[i].name, q[i].cyc, cyc);
        end else if (act !== req) begin
          errors++;
          $display("FAIL %s @%0d: got so=%h ri=%h fa=%h pe=%h irq=%b, want so=%h ri=%h fa=%h pe=%h irq=%b",
                   q[i].name, cyc, act[32:25], act[24:17], act[16:9], act[8:1], act[0],
                   req[32:25], req[24:17], req[16:9], req[8:1], req[0]);
        end
        q.delete(i);
      end
    end
  end

  initial begin
    int r, b, c, d, e, f, g, p, qq, budget;
    reset = 1'b1; a_in = '0; a_mask = '0; a_ack = '0;
    b_reset = 1'b1; b_in = '0; b_mask = 8'hFF; b_ack = '0;

    // Reset release with ch0 held high
    wait_until(2);
    r = cyc;
    push(r, 0, "a_reset", 8'h0, 8'h0, 8'h0, 8'h0, 1'b0);
    reset = 1'b0; a_in = 4'b0001;
    push(r + 31 + L, 0, "a_rise_pre",  8'h0, 8'h0, 8'h0, 8'h0, 1'b0);
    push(r + 32 + L, 0, "a_rise_edge", 8'h1, 8'h1, 8'h0, 8'h0, 1'b0);
    push(r + 33 + L, 0, "a_rise_post", 8'h1, 8'h0, 8'h0, 8'h0, 1'b0);

    // 1-cycle bounce on a settled-high channel must not move the output
    wait_until(r + 40);
    for (int k = 0; k < 40; k++) begin
      a_in[0] = k[0];
      push(cyc + 1, 0, "a_bounce", 8'h1, 8'h0, 8'h0, 8'h0, 1'b0);
      wait_until(cyc + 1);
    end
    a_in[0] = 1'b1;
    wait_until(cyc + 4);

    // Settled high then steady low: fall after 64 cycles
    b = cyc;
    a_in[0] = 1'b0;
    push(b + 63 + L, 0, "a_fall_pre",  8'h1, 8'h0, 8'h0, 8'h0, 1'b0);
    push(b + 64 + L, 0, "a_fall_edge", 8'h0, 8'h0, 8'h1, 8'h0, 1'b0);
    push(b + 65 + L, 0, "a_fall_post", 8'h0, 8'h0, 8'h0, 8'h0, 1'b0);

    // Masked interrupt: ch1 enabled, ch3 not
    wait_until(b + 70 + L);
    c = cyc;
    a_mask = 4'b0010; a_in = 4'b1010;
    push(c + 64 + L, 0, "a_irq_set",  8'hA, 8'hA, 8'h0, 8'h2, 1'b1);
    push(c + 65 + L, 0, "a_irq_hold", 8'hA, 8'h0, 8'h0, 8'h2, 1'b1);
    d = c + 70 + L;
    wait_until(d);
    a_ack = 4'b0010;
    push(d + 1, 0, "a_irq_ack", 8'hA, 8'h0, 8'h0, 8'h0, 1'b0);
    wait_until(d + 1);
    a_ack = 4'b0000;

    // ch1 falls, sets pending again
    e = d + 5;
    wait_until(e);
    a_in = 4'b1000;
    push(e + 64 + L, 0, "a_ch1_fall", 8'h8, 8'h0, 8'h2, 8'h2, 1'b1);

    // Ack coincident with a new ch1 rise: set wins
    f = e + 70 + L;
    wait_until(f);
    a_in = 4'b1010;
    wait_until(f + 63 + L);
    a_ack = 4'b0010;
    push(f + 64 + L, 0, "a_ack_vs_set", 8'hA, 8'h2, 8'h0, 8'h2, 1'b1);
    wait_until(f + 64 + L);
    a_ack = 4'b0000;
    push(f + 65 + L, 0, "a_set_kept", 8'hA, 8'h0, 8'h0, 8'h2, 1'b1);
    wait_until(f + 66 + L);
    a_mask = 4'b0000;
    push(f + 68 + L, 0, "a_mask_keeps", 8'hA, 8'h0, 8'h0, 8'h2, 1'b1);
    g = f + 70 + L;
    wait_until(g);
    a_ack = 4'b0010;
    push(g + 1, 0, "a_final_ack", 8'hA, 8'h0, 8'h0, 8'h0, 1'b0);
    wait_until(g + 1);
    a_ack = 4'b0000;

    // Instance B: 8 channels, CNT_W=3, OUT_INIT=1
    wait_until(g + 5);
    p = cyc;
    push(p, 1, "b_reset", 8'hFF, 8'h0, 8'h0, 8'h0, 1'b0);
    b_reset = 1'b0; b_in = 8'h00;
    push(p + 4 + L, 1, "b_fall_pre",  8'hFF, 8'h0, 8'h0,  8'h0,  1'b0);
    push(p + 5 + L, 1, "b_fall_edge", 8'h00, 8'h0, 8'hFF, 8'hFF, 1'b1);
    push(p + 6 + L, 1, "b_fall_post", 8'h00, 8'h0, 8'h0,  8'hFF, 1'b1);

    // Reset mid-swing returns counters to midpoint and outputs to init
    qq = p + 10 + L;
    wait_until(qq);
    b_in = 8'hFF;
    wait_until(qq + 3);
    b_reset = 1'b1;
    push(qq + 4, 1, "b_mid_reset", 8'hFF, 8'h0, 8'h0, 8'h0, 1'b0);
    wait_until(qq + 4);
    b_reset = 1'b0; b_in = 8'h00;
    push(qq + 8 + L, 1, "b_refall_pre",  8'hFF, 8'h0, 8'h0,  8'h0,  1'b0);
    push(qq + 9 + L, 1, "b_refall_edge", 8'h00, 8'h0, 8'hFF, 8'hFF, 1'b1);

    // Drain the scoreboard with a bounded wait
    budget = 200;
    while (q.size() != 0 && budget > 0) begin
      @(posedge clock);
      budget--;
    end
    if (q.size() != 0) begin
      foreach (q[i]) begin
        checks++;
        errors++;
        $display("FAIL %s: expectation for cycle %0d never checked", q[i].name, q[i].cyc);
      end
    end
    @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
